psum_acc_reader: RTL

// - Read side of the partial-sum memory (pmem) protocol.
// - After all kij passes have written per-kij psums into pmem, this block walks every output pixel (onij).
// - For each pixel it issues the LEN_KIJ shifted pmem reads and drives acc so the SFU sums them.
// - It then presents the finished pixel with a valid/ready handshake, replacing the hand-sequenced readout.

---
 rtl/psum_acc_reader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/psum_acc_reader.sv
// Read side of the partial-sum memory: per output pixel, issue the shifted kij
// reads with SFU accumulate control, then present the finished pixel via valid/ready.
module psum_acc_reader #(
  parameter int LEN_KIJ      = 9,
  parameter int LEN_ONIJ     = 16,
  parameter int LEN_NIJ      = 36,
  parameter int A_PAD_NI_DIM = 6,
  parameter int O_NI_DIM     = 4,
  parameter int KI_DIM       = 3,
  parameter int ADDR_BW      = 11
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        out_ready,
  output logic                        CEN_pmem,
  output logic                        WEN_pmem,
  output logic [ADDR_BW-1:0]          A_pmem,
  output logic                        acc,
  output logic                        acc_clr,
  output logic                        out_valid,
  output logic [$clog2(LEN_ONIJ)-1:0] out_idx,
  output logic                        busy,
  output logic                        done,
  output logic [2:0]                  dbg_state_o
);

  localparam int OW  = $clog2(LEN_ONIJ);
  localparam int JW  = $clog2(LEN_KIJ);
  localparam int ORW = (O_NI_DIM > 1) ? $clog2(O_NI_DIM) : 1;
  localparam int KRW = (KI_DIM > 1) ? $clog2(KI_DIM) : 1;

  localparam logic [OW-1:0]      O_LAST    = OW'(LEN_ONIJ - 1);
  localparam logic [JW-1:0]      J_LAST    = JW'(LEN_KIJ - 1);
  localparam logic [ORW-1:0]     OCOL_LAST = ORW'(O_NI_DIM - 1);
  localparam logic [KRW-1:0]     KCOL_LAST = KRW'(KI_DIM - 1);
  localparam logic [ADDR_BW-1:0] PAD_A     = ADDR_BW'(A_PAD_NI_DIM);
  localparam logic [ADDR_BW-1:0] NIJ_A     = ADDR_BW'(LEN_NIJ);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_READ   = 3'd2,
    S_TAIL   = 3'd3,
    S_SETTLE = 3'd4,
    S_EMIT   = 3'd5,
    S_FIN    = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic [OW-1:0]      o_q, o_d;
  logic [ORW-1:0]     orow_q, orow_d, ocol_q, ocol_d;
  logic [JW-1:0]      j_q, j_d;
  logic [KRW-1:0]     krow_q, krow_d, kcol_q, kcol_d;
  logic [ADDR_BW-1:0] kbase_q, kbase_d;

  logic               cen_d, acc_d, acc_clr_d, out_valid_d, busy_d, done_d;
  logic [ADDR_BW-1:0] addr_d;
  logic [ADDR_BW-1:0] rd_addr;

  // Handshake: a pixel transfers on any posedge where out_valid and out_ready are
  // both high; out_valid/out_idx hold steady until that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      o_q       <= '0;
      orow_q    <= '0;
      ocol_q    <= '0;
      j_q       <= '0;
      krow_q    <= '0;
      kcol_q    <= '0;
      kbase_q   <= '0;
      CEN_pmem  <= 1'b1;
      A_pmem    <= '0;
      acc       <= 1'b0;
      acc_clr   <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      o_q       <= o_d;
      orow_q    <= orow_d;
      ocol_q    <= ocol_d;
      j_q       <= j_d;
      krow_q    <= krow_d;
      kcol_q    <= kcol_d;
      kbase_q   <= kbase_d;
      CEN_pmem  <= cen_d;
      A_pmem    <= addr_d;
      acc       <= acc_d;
      acc_clr   <= acc_clr_d;
      out_valid <= out_valid_d;
      out_idx   <= o_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_CLR;
      S_CLR:    state_d = S_READ;
      S_READ:   if (j_q == J_LAST) state_d = S_TAIL;
      S_TAIL:   state_d = S_SETTLE;
      S_SETTLE: state_d = S_EMIT;
      S_EMIT:   if (out_ready) state_d = (o_q == O_LAST) ? S_FIN : S_CLR;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Pixel and kernel walkers; kbase carries j*LEN_NIJ so no multiply by j is needed.
  always_comb begin
    o_d     = o_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    j_d     = j_q;
    krow_d  = krow_q;
    kcol_d  = kcol_q;
    kbase_d = kbase_q;
    if (state_q == S_IDLE && start) begin
      o_d    = '0;
      orow_d = '0;
      ocol_d = '0;
    end
    if (state_q == S_EMIT && out_ready && o_q != O_LAST) begin
      o_d = o_q + OW'(1);
      if (ocol_q == OCOL_LAST) begin
        ocol_d = '0;
        orow_d = orow_q + ORW'(1);
      end else begin
        ocol_d = ocol_q + ORW'(1);
      end
    end
    if (state_d == S_CLR) begin
      j_d     = '0;
      krow_d  = '0;
      kcol_d  = '0;
      kbase_d = '0;
    end
    if (state_q == S_READ && j_q != J_LAST) begin
      j_d     = j_q + JW'(1);
      kbase_d = kbase_q + NIJ_A;
      if (kcol_q == KCOL_LAST) begin
        kcol_d = '0;
        krow_d = krow_q + KRW'(1);
      end else begin
        kcol_d = kcol_q + KRW'(1);
      end
    end
  end

  assign rd_addr = ADDR_BW'(orow_d) * PAD_A + ADDR_BW'(ocol_d)
                 + ADDR_BW'(krow_d) * PAD_A + ADDR_BW'(kcol_d) + kbase_d;

  // Outputs are decoded from the next state so the registered copies line up
  // with the state they describe.
  always_comb begin
    cen_d       = (state_d != S_READ);
    acc_d       = (state_d == S_READ && j_d != '0) || (state_d == S_TAIL);
    acc_clr_d   = (state_d == S_CLR);
    out_valid_d = (state_d == S_EMIT);
    busy_d      = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d      = (state_d == S_FIN);
    addr_d      = (state_d == S_READ) ? rd_addr : A_pmem;
  end

  assign WEN_pmem    = 1'b1;
  assign dbg_state_o = state_q;

endmodule
